// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks.
// Holds the FSM state type, the default operand width and the counter sizing helper.
package serial_arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 4;
    localparam int CNT_WIDTH     = $clog2(DEFAULT_WIDTH);

    // A one-bit operand still needs a one-bit counter.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/full_sub_1bit.sv
// Single-bit full subtractor: d = a - b - bin, with borrow-out.
// Purely combinational; the serial subtractor reuses one instance for every bit.
module full_sub_1bit (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    // Borrow out when b exceeds a, or when they match and a borrow comes in.
    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_sub_4bits.sv
// Bit-serial subtractor: Q = A - B - bin, one bit per clock, LSB first.
// Q[WIDTH] is the borrow-out; Q only changes on the edge that enters DONE.
module serial_sub_4bits
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             bin,
    output logic [WIDTH:0]   Q,
    output logic             busy,
    output logic             done
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] result_next;
    logic             br;
    logic [CW-1:0]    cnt;
    logic             d;
    logic             bout;
    logic             start;
    logic             last;

    full_sub_1bit u_cell (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .bin  (br),
        .d    (d),
        .bout (bout)
    );

    assign last        = (cnt == CW'(WIDTH - 1));
    assign result_next = {d, result[WIDTH-1:1]};
    assign busy        = (state == RUN);
    assign done        = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // A start is only accepted from IDLE or DONE, so operands in flight stay untouched.
    always_comb begin
        next_state = state;
        start      = 1'b0;
        case (state)
            IDLE: begin
                if (enable) begin
                    start      = 1'b1;
                    next_state = RUN;
                end
            end
            RUN: begin
                if (last) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                if (enable) begin
                    start      = 1'b1;
                    next_state = RUN;
                end else begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // The final bit and its borrow-out go straight into Q on the edge entering DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr   <= '0;
            b_sr   <= '0;
            result <= '0;
            br     <= 1'b0;
            cnt    <= '0;
            Q      <= '0;
        end else if (start) begin
            a_sr <= A;
            b_sr <= B;
            br   <= bin;
            cnt  <= '0;
        end else if (state == RUN) begin
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            br     <= bout;
            result <= result_next;
            cnt    <= cnt + CW'(1);
            if (last) begin
                Q <= {bout, result_next};
            end
        end
    end

endmodule
